mac_reg_responder: RTL and testbench
====================================

# mac_reg_responder

Avalon-MM register responder that models the MAC control register space driven by the MAC configuration master. It accepts single-word read/write accesses, stalls each one with `waitrequest` for a programmable latency, and holds the MAC configuration registers. It decodes the stored values into MAC control outputs. It stands in for the MAC register file in simulation and in FPGA builds that terminate the config bus locally.

## Interface
Parameters:
- `ACCESS_LAT`, default 2: BUSY cycles per access before completion; legal range 0–15.
- `REV_VAL`, default 32'h0000_0901: value returned at address 0x00.
- `IPG_RST`, default 12: reset value of `tx_ipg_length`.
- `FRM_RST`, default 1518: reset value of `frm_length`.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `address` in 8: dword address.
- `read` in 1: read request.
- `write` in 1: write request.
- `writedata` in 32: write data.
- `readdata` out 32: read data, valid in the ACK cycle.
- `waitrequest` out 1: high except in the ACK cycle.
- `tx_ena`, `rx_ena`, `eth_speed`, `promis_en`, `pad_en`, `crc_fwd`, `loop_ena`, `rx_err_disc` out 1 each: command_config bits 0, 1, 3, 4, 5, 6, 15, 26.
- `mac_addr` out 48: `{addr1[15:0], addr0[31:0]}`.
- `frm_length` out 16: frame length register.
- `pause_quant` out 16: pause quanta register.
- `tx_ipg_length` out 5: inter-packet gap register.
- `tx_section_empty`, `tx_section_full`, `tx_almost_empty`, `tx_almost_full` out 16 each: FIFO threshold registers.
- `cnt_reset` out 1: one-cycle pulse.
- `pcs_if_mode`, `pcs_ctrl` out 16 each: present only with `MAC_REGS_SGMII_EN`.

## Operation
- FSM states: IDLE, BUSY, ACK.
- IDLE → BUSY when `read|write` is high.
  - Address, operation and data are latched on that edge.
  - With `ACCESS_LAT`=0, IDLE → ACK directly.
- BUSY holds for `ACCESS_LAT` cycles using a 4-bit down-counter, then goes to ACK.
- ACK → IDLE unconditionally. ACK lasts exactly one cycle.
- If `read` and `write` are high together, the access is a write.
- Register map:
  - 0x00 rev: read-only, `REV_VAL`.
  - 0x01 scratch.
  - 0x02 command_config.
  - 0x03 addr0.
  - 0x04 addr1[15:0].
  - 0x05 frm_length[15:0].
  - 0x06 pause_quant[15:0].
  - 0x09 tx_section_empty.
  - 0x0A tx_section_full.
  - 0x0D tx_almost_empty.
  - 0x0E tx_almost_full.
  - 0x17 tx_ipg_length[4:0].
  - Unused bits read 0.
- Unmapped addresses and writes to read-only registers:
  - Reads return 0.
  - Writes are ignored.
  - The access still completes normally.
- command_config special bits:
  - Bit 13 (SW_RESET) is self-clearing. When written as 1, `tx_ena` and `rx_ena` are forced to 0 for 8 cycles after ACK. Then bit 13 clears and the stored bits take effect.
  - Bit 31 (CNT_RESET) is never stored. Writing it as 1 pulses `cnt_reset` high for exactly one cycle, the cycle after ACK. It always reads back 0.
- Reset values:
  - All registers are 0, except `frm_length`=`FRM_RST` and `tx_ipg_length`=`IPG_RST`.
  - `waitrequest`=1, `readdata`=0, `cnt_reset`=0, FSM in IDLE.
  - Every output equals its decoded reset register value.

## Timing
- Request seen at edge N.
  - ACK occupies cycle N+1+`ACCESS_LAT`; `waitrequest`=0 only in that cycle.
  - `readdata` is registered from the latched address, is stable for the whole ACK cycle, and is held after it.
- A write updates its register on the edge that ends ACK. Outputs reflect the new value from the following cycle.
- The cycle after ACK is IDLE with `waitrequest`=1. A request sampled there is treated as a new access. Back-to-back accesses therefore cost `ACCESS_LAT`+2 cycles each.
- Request signals are ignored in BUSY and ACK. The master must hold them until it sees `waitrequest` low.
- Asynchronous reset mid-access:
  - The FSM returns to IDLE and the access is dropped; no register is written.
  - The SW_RESET timer clears and `cnt_reset` is 0.

## Configuration
- With `MAC_REGS_SGMII_EN`:
  - 0x80 `pcs_ctrl`[15:0], reset 16'h1140.
  - 0x94 `pcs_if_mode`[15:0], reset 16'h0000.
  - Both are read/write and driven to the matching ports.
- Without the macro:
  - 0x80 and 0x94 are unmapped (read 0, writes ignored).
  - `pcs_ctrl` and `pcs_if_mode` ports are absent.

## Structure
- Shared package `mac_regs_pkg` holds:
  - register address constants;
  - command_config bit-index constants;
  - FSM state encoding;
  - reset-value constants.
- The configuration master imports the same package.
- One sub-module, `mac_reg_file`, holds storage, write decode, read mux and SW_RESET timer.
- The top module holds the handshake FSM and latency counter.

## Test plan
- Read 0x00 with `ACCESS_LAT`=2 → `waitrequest` low exactly at cycle N+3, `readdata`=32'h0000_0901.
- Write 0x01 = 32'ha5a5_a5a5, then read 0x01 → readback 32'ha5a5_a5a5; each access takes 4 cycles.
- Write 0x02 = 32'h0400_0033 → `tx_ena`, `rx_ena`, `promis_en`, `pad_en`, `rx_err_disc` = 1; `loop_ena` = 0; readback 32'h0400_0033.
- Write 0x02 = 32'h8000_2003:
  - `cnt_reset` pulses for one cycle;
  - `tx_ena` and `rx_ena` stay 0 for 8 cycles, then go to 1;
  - readback 32'h0000_0003.
- Write 0x03 = 32'habababab and 0x04 = 32'h0000abab → `mac_addr`=48'habab_abababab. Read 0x40 → 0. Write then read 0x00 → still `REV_VAL`.
- Assert `rst_n` low in the BUSY cycle of a write 0x05 = 64 → `frm_length` = 1518 and `waitrequest`=1. With the macro on, read 0x80 → 32'h0000_1140.

Source files
------------

// File: rtl/mac_regs_pkg.sv
// Shared definitions for the MAC control register space: addresses, command_config
// bit positions, handshake FSM encoding and reset values. Also imported by the config master.
package mac_regs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam logic [7:0] ADDR_REV            = 8'h00;
    localparam logic [7:0] ADDR_SCRATCH        = 8'h01;
    localparam logic [7:0] ADDR_CMD_CFG        = 8'h02;
    localparam logic [7:0] ADDR_MAC_0          = 8'h03;
    localparam logic [7:0] ADDR_MAC_1          = 8'h04;
    localparam logic [7:0] ADDR_FRM_LENGTH     = 8'h05;
    localparam logic [7:0] ADDR_PAUSE_QUANT    = 8'h06;
    localparam logic [7:0] ADDR_TX_SEC_EMPTY   = 8'h09;
    localparam logic [7:0] ADDR_TX_SEC_FULL    = 8'h0A;
    localparam logic [7:0] ADDR_TX_ALM_EMPTY   = 8'h0D;
    localparam logic [7:0] ADDR_TX_ALM_FULL    = 8'h0E;
    localparam logic [7:0] ADDR_TX_IPG_LENGTH  = 8'h17;
    localparam logic [7:0] ADDR_PCS_CTRL       = 8'h80;
    localparam logic [7:0] ADDR_PCS_IF_MODE    = 8'h94;

    localparam int CMD_TX_ENA      = 0;
    localparam int CMD_RX_ENA      = 1;
    localparam int CMD_ETH_SPEED   = 3;
    localparam int CMD_PROMIS_EN   = 4;
    localparam int CMD_PAD_EN      = 5;
    localparam int CMD_CRC_FWD     = 6;
    localparam int CMD_SW_RESET    = 13;
    localparam int CMD_LOOP_ENA    = 15;
    localparam int CMD_RX_ERR_DISC = 26;
    localparam int CMD_CNT_RESET   = 31;

    localparam logic [15:0] PCS_CTRL_RST    = 16'h1140;
    localparam logic [15:0] PCS_IF_MODE_RST = 16'h0000;
    localparam logic [3:0]  SW_RESET_CYCLES = 4'd8;

endpackage

// File: rtl/mac_reg_file.sv
// MAC register storage: write decode, read mux, SW_RESET hold-off timer and counter-reset pulse.
// Optional PCS registers are compiled in with MAC_REGS_SGMII_EN.
module mac_reg_file
    import mac_regs_pkg::*;
#(
    parameter logic [31:0] REV_VAL = 32'h0000_0901,
    parameter int          IPG_RST = 12,
    parameter int          FRM_RST = 1518
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        wr_en_i,
    input  logic [7:0]  wr_addr_i,
    input  logic [31:0] wr_data_i,
    input  logic [7:0]  rd_addr_i,
    output logic [31:0] rd_data_o,
    output logic [30:0] cmd_o,
    output logic        sw_reset_busy_o,
    output logic [47:0] mac_addr_o,
    output logic [15:0] frm_length_o,
    output logic [15:0] pause_quant_o,
    output logic [4:0]  tx_ipg_length_o,
    output logic [15:0] tx_section_empty_o,
    output logic [15:0] tx_section_full_o,
    output logic [15:0] tx_almost_empty_o,
    output logic [15:0] tx_almost_full_o,
    output logic        cnt_reset_o
`ifdef MAC_REGS_SGMII_EN
    ,
    output logic [15:0] pcs_ctrl_o,
    output logic [15:0] pcs_if_mode_o
`endif
);

    logic [31:0] scratch_q;
    logic [30:0] cmd_q;       // bit 31 (CNT_RESET) is never stored
    logic [31:0] addr0_q;
    logic [15:0] addr1_q;
    logic [15:0] frm_q;
    logic [15:0] pause_q;
    logic [4:0]  ipg_q;
    logic [15:0] sec_empty_q, sec_full_q, alm_empty_q, alm_full_q;
    logic [3:0]  sw_rst_cnt_q;
    logic        cnt_reset_q;
`ifdef MAC_REGS_SGMII_EN
    logic [15:0] pcs_ctrl_q, pcs_if_mode_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            scratch_q    <= '0;
            cmd_q        <= '0;
            addr0_q      <= '0;
            addr1_q      <= '0;
            frm_q        <= 16'(FRM_RST);
            pause_q      <= '0;
            ipg_q        <= 5'(IPG_RST);
            sec_empty_q  <= '0;
            sec_full_q   <= '0;
            alm_empty_q  <= '0;
            alm_full_q   <= '0;
            sw_rst_cnt_q <= '0;
            cnt_reset_q  <= 1'b0;
`ifdef MAC_REGS_SGMII_EN
            pcs_ctrl_q    <= PCS_CTRL_RST;
            pcs_if_mode_q <= PCS_IF_MODE_RST;
`endif
        end else begin
            cnt_reset_q <= 1'b0;
            if (sw_rst_cnt_q != 4'd0) begin
                sw_rst_cnt_q <= sw_rst_cnt_q - 4'd1;
                if (sw_rst_cnt_q == 4'd1)
                    cmd_q[CMD_SW_RESET] <= 1'b0;
            end
            // A new write takes precedence over the timer's self-clear in the same cycle.
            if (wr_en_i) begin
                case (wr_addr_i)
                    ADDR_SCRATCH:       scratch_q   <= wr_data_i;
                    ADDR_CMD_CFG: begin
                        cmd_q       <= wr_data_i[30:0];
                        cnt_reset_q <= wr_data_i[CMD_CNT_RESET];
                        if (wr_data_i[CMD_SW_RESET])
                            sw_rst_cnt_q <= SW_RESET_CYCLES;
                    end
                    ADDR_MAC_0:         addr0_q     <= wr_data_i;
                    ADDR_MAC_1:         addr1_q     <= wr_data_i[15:0];
                    ADDR_FRM_LENGTH:    frm_q       <= wr_data_i[15:0];
                    ADDR_PAUSE_QUANT:   pause_q     <= wr_data_i[15:0];
                    ADDR_TX_SEC_EMPTY:  sec_empty_q <= wr_data_i[15:0];
                    ADDR_TX_SEC_FULL:   sec_full_q  <= wr_data_i[15:0];
                    ADDR_TX_ALM_EMPTY:  alm_empty_q <= wr_data_i[15:0];
                    ADDR_TX_ALM_FULL:   alm_full_q  <= wr_data_i[15:0];
                    ADDR_TX_IPG_LENGTH: ipg_q       <= wr_data_i[4:0];
`ifdef MAC_REGS_SGMII_EN
                    ADDR_PCS_CTRL:      pcs_ctrl_q    <= wr_data_i[15:0];
                    ADDR_PCS_IF_MODE:   pcs_if_mode_q <= wr_data_i[15:0];
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data_o = '0;
        case (rd_addr_i)
            ADDR_REV:           rd_data_o = REV_VAL;
            ADDR_SCRATCH:       rd_data_o = scratch_q;
            ADDR_CMD_CFG:       rd_data_o = {1'b0, cmd_q};
            ADDR_MAC_0:         rd_data_o = addr0_q;
            ADDR_MAC_1:         rd_data_o = {16'h0, addr1_q};
            ADDR_FRM_LENGTH:    rd_data_o = {16'h0, frm_q};
            ADDR_PAUSE_QUANT:   rd_data_o = {16'h0, pause_q};
            ADDR_TX_SEC_EMPTY:  rd_data_o = {16'h0, sec_empty_q};
            ADDR_TX_SEC_FULL:   rd_data_o = {16'h0, sec_full_q};
            ADDR_TX_ALM_EMPTY:  rd_data_o = {16'h0, alm_empty_q};
            ADDR_TX_ALM_FULL:   rd_data_o = {16'h0, alm_full_q};
            ADDR_TX_IPG_LENGTH: rd_data_o = {27'h0, ipg_q};
`ifdef MAC_REGS_SGMII_EN
            ADDR_PCS_CTRL:      rd_data_o = {16'h0, pcs_ctrl_q};
            ADDR_PCS_IF_MODE:   rd_data_o = {16'h0, pcs_if_mode_q};
`endif
            default:            rd_data_o = '0;
        endcase
    end

    assign cmd_o              = cmd_q;
    assign sw_reset_busy_o    = (sw_rst_cnt_q != 4'd0);
    assign mac_addr_o         = {addr1_q, addr0_q};
    assign frm_length_o       = frm_q;
    assign pause_quant_o      = pause_q;
    assign tx_ipg_length_o    = ipg_q;
    assign tx_section_empty_o = sec_empty_q;
    assign tx_section_full_o  = sec_full_q;
    assign tx_almost_empty_o  = alm_empty_q;
    assign tx_almost_full_o   = alm_full_q;
    assign cnt_reset_o        = cnt_reset_q;
`ifdef MAC_REGS_SGMII_EN
    assign pcs_ctrl_o         = pcs_ctrl_q;
    assign pcs_if_mode_o      = pcs_if_mode_q;
`endif

endmodule

// File: rtl/mac_reg_responder.sv
// Avalon-MM responder for the MAC control register space: waitrequest handshake with
// programmable access latency in front of mac_reg_file. PCS ports exist with MAC_REGS_SGMII_EN.
//   state   | meaning
//   IDLE    | waiting for read|write; request latched on entry to BUSY/ACK
//   BUSY    | stalling ACCESS_LAT cycles on the down-counter
//   ACK     | waitrequest low for one cycle; a pending write commits at its end
module mac_reg_responder
    import mac_regs_pkg::*;
#(
    parameter int          ACCESS_LAT = 2,
    parameter logic [31:0] REV_VAL    = 32'h0000_0901,
    parameter int          IPG_RST    = 12,
    parameter int          FRM_RST    = 1518
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        tx_ena,
    output logic        rx_ena,
    output logic        eth_speed,
    output logic        promis_en,
    output logic        pad_en,
    output logic        crc_fwd,
    output logic        loop_ena,
    output logic        rx_err_disc,
    output logic [47:0] mac_addr,
    output logic [15:0] frm_length,
    output logic [15:0] pause_quant,
    output logic [4:0]  tx_ipg_length,
    output logic [15:0] tx_section_empty,
    output logic [15:0] tx_section_full,
    output logic [15:0] tx_almost_empty,
    output logic [15:0] tx_almost_full,
    output logic        cnt_reset
`ifdef MAC_REGS_SGMII_EN
    ,
    output logic [15:0] pcs_if_mode,
    output logic [15:0] pcs_ctrl
`endif
);

    localparam logic [3:0] LAT_M1 = (ACCESS_LAT == 0) ? 4'd0 : 4'(ACCESS_LAT - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic [7:0]  addr_q;
    logic        wr_q;
    logic [31:0] wdata_q;
    logic [31:0] readdata_q;
    logic        waitreq_q;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        wr_en;
    logic [30:0] cmd;
    logic        sw_reset_busy;

    // With zero latency the ACK data must come from the address still on the bus.
    assign rd_addr = (state_q == ST_IDLE) ? address : addr_q;
    assign wr_en   = (state_q == ST_ACK) && wr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            readdata_q <= '0;
            waitreq_q  <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (read || write) begin
                        addr_q  <= address;
                        wr_q    <= write;
                        wdata_q <= writedata;
                        if (ACCESS_LAT == 0) begin
                            state_q    <= ST_ACK;
                            waitreq_q  <= 1'b0;
                            readdata_q <= rd_data;
                        end else begin
                            state_q <= ST_BUSY;
                            cnt_q   <= LAT_M1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= ST_ACK;
                        waitreq_q  <= 1'b0;
                        readdata_q <= rd_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_ACK: begin
                    state_q   <= ST_IDLE;
                    waitreq_q <= 1'b1;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    waitreq_q <= 1'b1;
                end
            endcase
        end
    end

    mac_reg_file #(
        .REV_VAL (REV_VAL),
        .IPG_RST (IPG_RST),
        .FRM_RST (FRM_RST)
    ) u_reg_file (
        .clk_i              (clk),
        .rst_n_i            (rst_n),
        .wr_en_i            (wr_en),
        .wr_addr_i          (addr_q),
        .wr_data_i          (wdata_q),
        .rd_addr_i          (rd_addr),
        .rd_data_o          (rd_data),
        .cmd_o              (cmd),
        .sw_reset_busy_o    (sw_reset_busy),
        .mac_addr_o         (mac_addr),
        .frm_length_o       (frm_length),
        .pause_quant_o      (pause_quant),
        .tx_ipg_length_o    (tx_ipg_length),
        .tx_section_empty_o (tx_section_empty),
        .tx_section_full_o  (tx_section_full),
        .tx_almost_empty_o  (tx_almost_empty),
        .tx_almost_full_o   (tx_almost_full),
        .cnt_reset_o        (cnt_reset)
`ifdef MAC_REGS_SGMII_EN
        ,
        .pcs_ctrl_o         (pcs_ctrl),
        .pcs_if_mode_o      (pcs_if_mode)
`endif
    );

    assign readdata    = readdata_q;
    assign waitrequest = waitreq_q;
    assign tx_ena      = cmd[CMD_TX_ENA] && !sw_reset_busy;
    assign rx_ena      = cmd[CMD_RX_ENA] && !sw_reset_busy;
    assign eth_speed   = cmd[CMD_ETH_SPEED];
    assign promis_en   = cmd[CMD_PROMIS_EN];
    assign pad_en      = cmd[CMD_PAD_EN];
    assign crc_fwd     = cmd[CMD_CRC_FWD];
    assign loop_ena    = cmd[CMD_LOOP_ENA];
    assign rx_err_disc = cmd[CMD_RX_ERR_DISC];

endmodule

// File: tb/tb_mac_reg_responder.sv
// Directed bench for mac_reg_responder at ACCESS_LAT=2; PCS checks follow MAC_REGS_SGMII_EN.
module tb_mac_reg_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  address = '0;
    logic        read = 1'b0;
    logic        write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        waitrequest;
    logic        tx_ena, rx_ena, eth_speed, promis_en, pad_en, crc_fwd, loop_ena, rx_err_disc;
    logic [47:0] mac_addr;
    logic [15:0] frm_length, pause_quant;
    logic [4:0]  tx_ipg_length;
    logic [15:0] tx_section_empty, tx_section_full, tx_almost_empty, tx_almost_full;
    logic        cnt_reset;
`ifdef MAC_REGS_SGMII_EN
    logic [15:0] pcs_if_mode, pcs_ctrl;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] rd;

    always #5 clk = ~clk;

    mac_reg_responder dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .address          (address),
        .read             (read),
        .write            (write),
        .writedata        (writedata),
        .readdata         (readdata),
        .waitrequest      (waitrequest),
        .tx_ena           (tx_ena),
        .rx_ena           (rx_ena),
        .eth_speed        (eth_speed),
        .promis_en        (promis_en),
        .pad_en           (pad_en),
        .crc_fwd          (crc_fwd),
        .loop_ena         (loop_ena),
        .rx_err_disc      (rx_err_disc),
        .mac_addr         (mac_addr),
        .frm_length       (frm_length),
        .pause_quant      (pause_quant),
        .tx_ipg_length    (tx_ipg_length),
        .tx_section_empty (tx_section_empty),
        .tx_section_full  (tx_section_full),
        .tx_almost_empty  (tx_almost_empty),
        .tx_almost_full   (tx_almost_full),
        .cnt_reset        (cnt_reset)
`ifdef MAC_REGS_SGMII_EN
        ,
        .pcs_if_mode      (pcs_if_mode),
        .pcs_ctrl         (pcs_ctrl)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one access starting in the current (IDLE) cycle; returns one cycle after ACK.
    task automatic access(input logic [7:0] a, input logic r, input logic w,
                          input logic [31:0] d, output logic [31:0] rdata);
        int k;
        address   = a;
        read      = r;
        write     = w;
        writedata = d;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (waitrequest && k < 20);
        chk("ack_latency", 64'(k), 64'(3));
        rdata = readdata;
        read  = 1'b0;
        write = 1'b0;
        @(posedge clk); #1;
        chk("wait_after_ack", 64'(waitrequest), 64'(1'b1));
        chk("rdata_held", 64'(readdata), 64'(rdata));
    endtask

    initial begin
        #12;
        chk("rst_waitreq", 64'(waitrequest), 64'(1'b1));
        chk("rst_readdata", 64'(readdata), 64'(32'h0));
        chk("rst_cnt_reset", 64'(cnt_reset), 64'(1'b0));
        chk("rst_frm", 64'(frm_length), 64'(16'd1518));
        chk("rst_ipg", 64'(tx_ipg_length), 64'(5'd12));
        chk("rst_tx_ena", 64'(tx_ena), 64'(1'b0));
        chk("rst_mac_addr", 64'(mac_addr), 64'(48'h0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        access(8'h00, 1'b1, 1'b0, 32'h0, rd);
        chk("rev_read", 64'(rd), 64'(32'h0000_0901));

        access(8'h01, 1'b0, 1'b1, 32'ha5a5_a5a5, rd);
        access(8'h01, 1'b1, 1'b0, 32'h0, rd);
        chk("scratch_read", 64'(rd), 64'(32'ha5a5_a5a5));

        access(8'h02, 1'b0, 1'b1, 32'h0400_0033, rd);
        chk("cfg_bits", 64'({tx_ena, rx_ena, eth_speed, promis_en, pad_en, crc_fwd, loop_ena, rx_err_disc}),
            64'(8'b1101_1001));
        chk("no_cnt_reset", 64'(cnt_reset), 64'(1'b0));
        access(8'h02, 1'b1, 1'b0, 32'h0, rd);
        chk("cmd_read", 64'(rd), 64'(32'h0400_0033));

        access(8'h02, 1'b0, 1'b1, 32'h8000_2003, rd);
        chk("cnt_reset_pulse", 64'(cnt_reset), 64'(1'b1));
        chk("swrst_tx_hold", 64'({tx_ena, rx_ena}), 64'(2'b00));
        for (int i = 2; i <= 8; i++) begin
            @(posedge clk); #1;
            chk("swrst_hold", 64'({tx_ena, rx_ena}), 64'(2'b00));
            if (i == 2) chk("cnt_reset_one", 64'(cnt_reset), 64'(1'b0));
        end
        @(posedge clk); #1;
        chk("swrst_release", 64'({tx_ena, rx_ena, promis_en}), 64'(3'b110));
        access(8'h02, 1'b1, 1'b0, 32'h0, rd);
        chk("cmd_selfclear", 64'(rd), 64'(32'h0000_0003));

        access(8'h02, 1'b0, 1'b1, 32'h0000_8048, rd);
        chk("cfg_bits2", 64'({tx_ena, rx_ena, eth_speed, promis_en, pad_en, crc_fwd, loop_ena, rx_err_disc}),
            64'(8'b0010_0110));

        access(8'h03, 1'b0, 1'b1, 32'habab_abab, rd);
        access(8'h04, 1'b0, 1'b1, 32'h0000_abab, rd);
        chk("mac_addr", 64'(mac_addr), 64'(48'habab_abab_abab));
        access(8'h40, 1'b1, 1'b0, 32'h0, rd);
        chk("unmapped_read", 64'(rd), 64'(32'h0));
        access(8'h00, 1'b0, 1'b1, 32'hffff_ffff, rd);
        access(8'h00, 1'b1, 1'b0, 32'h0, rd);
        chk("rev_ro", 64'(rd), 64'(32'h0000_0901));

        access(8'h06, 1'b1, 1'b1, 32'h1234_beef, rd);
        chk("rw_is_write", 64'(pause_quant), 64'(16'hbeef));
        access(8'h06, 1'b1, 1'b0, 32'h0, rd);
        chk("pause_read", 64'(rd), 64'(32'h0000_beef));

        access(8'h17, 1'b0, 1'b1, 32'hffff_ffff, rd);
        chk("ipg_out", 64'(tx_ipg_length), 64'(5'h1f));
        access(8'h17, 1'b1, 1'b0, 32'h0, rd);
        chk("ipg_read", 64'(rd), 64'(32'h0000_001f));

        access(8'h09, 1'b0, 1'b1, 32'h0000_0111, rd);
        access(8'h0A, 1'b0, 1'b1, 32'h0000_0222, rd);
        access(8'h0D, 1'b0, 1'b1, 32'h0000_0333, rd);
        access(8'h0E, 1'b0, 1'b1, 32'hffff_0444, rd);
        chk("fifo_thresh", 64'({tx_section_empty, tx_section_full, tx_almost_empty, tx_almost_full}),
            64'h0111_0222_0333_0444);
        access(8'h0E, 1'b1, 1'b0, 32'h0, rd);
        chk("alm_full_read", 64'(rd), 64'(32'h0000_0444));

`ifdef MAC_REGS_SGMII_EN
        access(8'h80, 1'b1, 1'b0, 32'h0, rd);
        chk("pcs_ctrl_rst", 64'(rd), 64'(32'h0000_1140));
        access(8'h94, 1'b0, 1'b1, 32'h0000_0003, rd);
        chk("pcs_if_mode", 64'(pcs_if_mode), 64'(16'h0003));
        access(8'h94, 1'b1, 1'b0, 32'h0, rd);
        chk("pcs_if_read", 64'(rd), 64'(32'h0000_0003));
`else
        access(8'h80, 1'b0, 1'b1, 32'h0000_dead, rd);
        access(8'h80, 1'b1, 1'b0, 32'h0, rd);
        chk("pcs_absent", 64'(rd), 64'(32'h0));
`endif

        // Reset lands in the BUSY cycle of a frm_length write.
        address   = 8'h05;
        write     = 1'b1;
        writedata = 32'd64;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_waitreq", 64'(waitrequest), 64'(1'b1));
        chk("rst_mid_frm", 64'(frm_length), 64'(16'd1518));
        write = 1'b0;
        #3;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_frm", 64'(frm_length), 64'(16'd1518));
        chk("post_rst_state", 64'({waitrequest, cnt_reset, tx_ena, loop_ena}), 64'(4'b1000));
        chk("post_rst_mac", 64'(mac_addr), 64'(48'h0));
        access(8'h05, 1'b1, 1'b0, 32'h0, rd);
        chk("frm_read", 64'(rd), 64'(32'd1518));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
